code_check_seq: RTL and testbench

Parametrised keypad code checker and the successor of the fixed 4-digit, 2-bit checker in the alarm module. It accepts digits strobed by the keypad decoder on `KB_RECV`, assembles a `CODE_LEN`-digit entry, and compares it against `VALID_KEY`. It reports OK or ERROR with a one-cycle result strobe, aborts stalled entries after a timeout, and locks out entry after repeated failures. Everything runs on the system clock; the asynchronous keypad strobe is synchronised internally.

---
 rtl/code_check_seq.sv | 215 +++++++++++++++++++++
 tb/tb_code_check_seq.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/code_check_seq.sv
// code_check_seq: keypad code checker with entry timeout and an optional failure lockout.
// Build option: define CODE_CHECK_LOCKOUT_EN to include the fail counter and LOCKOUT state.
`timescale 1ns/1ps
module code_check_seq #(
    parameter int unsigned DIGIT_W        = 2,
    parameter int unsigned CODE_LEN       = 4,
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
    parameter int unsigned MAX_TRIES      = 3,
    parameter int unsigned LOCK_CYCLES    = 500_000_000
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic                             KB_RECV,
    input  logic [DIGIT_W-1:0]               KB_IN,
    input  logic [DIGIT_W*CODE_LEN-1:0]      VALID_KEY,
    output logic [1:0]                       KEY_STATUS,
    output logic                             RESULT_STB,
    output logic                             LOCKED,
    output logic [$clog2(CODE_LEN+1)-1:0]    DIGIT_CNT
);
    localparam int unsigned KEY_W = DIGIT_W * CODE_LEN;
    localparam int unsigned CNT_W = $clog2(CODE_LEN + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] ST_OK   = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_ERR  = 2'd2;
    localparam logic [1:0] ST_NONE = 2'd3;

`ifdef CODE_CHECK_LOCKOUT_EN
    localparam int unsigned FAIL_W = $clog2(MAX_TRIES + 1);
    localparam int unsigned LOCK_W = $clog2(LOCK_CYCLES + 1);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ENTRY = 2'd1, S_CHECK = 2'd2, S_LOCKOUT = 2'd3} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ENTRY = 2'd1, S_CHECK = 2'd2} state_t;
`endif

    state_t             r_state, w_state_nxt;
    logic               r_recv_s1, r_recv_s2, r_recv_s3;
    logic [DIGIT_W-1:0] r_in_s1, r_in_s2;
    logic               w_kb_rise;
    logic [KEY_W-1:0]   r_buf, w_buf_nxt, w_buf_shift;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [TMO_W-1:0]   r_tmo, w_tmo_nxt;
    logic [1:0]         r_status, w_status_nxt;
    logic               r_stb, w_stb_nxt;
    logic               w_match, w_tmo_hit, w_last_digit;

`ifdef CODE_CHECK_LOCKOUT_EN
    logic [FAIL_W-1:0]  r_fail, w_fail_nxt;
    logic [LOCK_W-1:0]  r_lock, w_lock_nxt;
    logic               r_locked, w_locked_nxt;
    logic               w_fail_hit, w_lock_hit;

    assign w_fail_hit = (r_fail >= FAIL_W'(MAX_TRIES - 1));
    assign w_lock_hit = (r_lock >= LOCK_W'(LOCK_CYCLES - 1));
    assign LOCKED     = r_locked;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = ^{32'(MAX_TRIES), 32'(LOCK_CYCLES)};
    assign LOCKED       = 1'b0;
`endif

    // Keypad strobe/data synchroniser and rising-edge detect
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_recv_s1 <= 1'b0;
            r_recv_s2 <= 1'b0;
            r_recv_s3 <= 1'b0;
            r_in_s1   <= '0;
            r_in_s2   <= '0;
        end else begin
            r_recv_s1 <= KB_RECV;
            r_recv_s2 <= r_recv_s1;
            r_recv_s3 <= r_recv_s2;
            r_in_s1   <= KB_IN;
            r_in_s2   <= r_in_s1;
        end
    end

    assign w_kb_rise    = r_recv_s2 & ~r_recv_s3;
    // New digits enter at the top so that after CODE_LEN digits the first one sits in the LSBs
    assign w_buf_shift  = {r_in_s2, r_buf[KEY_W-1:DIGIT_W]};
    assign w_match      = (r_buf == VALID_KEY);
    assign w_tmo_hit    = (r_tmo >= TMO_W'(TIMEOUT_CYCLES - 1));
    assign w_last_digit = (r_cnt == CNT_W'(CODE_LEN - 1));

    // State and datapath registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= S_IDLE;
            r_buf    <= '0;
            r_cnt    <= '0;
            r_tmo    <= '0;
            r_status <= ST_NONE;
            r_stb    <= 1'b0;
`ifdef CODE_CHECK_LOCKOUT_EN
            r_fail   <= '0;
            r_lock   <= '0;
            r_locked <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_buf    <= w_buf_nxt;
            r_cnt    <= w_cnt_nxt;
            r_tmo    <= w_tmo_nxt;
            r_status <= w_status_nxt;
            r_stb    <= w_stb_nxt;
`ifdef CODE_CHECK_LOCKOUT_EN
            r_fail   <= w_fail_nxt;
            r_lock   <= w_lock_nxt;
            r_locked <= w_locked_nxt;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_kb_rise) w_state_nxt = S_ENTRY;
            S_ENTRY: begin
                if (w_kb_rise && w_last_digit) w_state_nxt = S_CHECK;
                else if (!w_kb_rise && w_tmo_hit) w_state_nxt = S_IDLE;
            end
            S_CHECK: begin
`ifdef CODE_CHECK_LOCKOUT_EN
                w_state_nxt = (!w_match && w_fail_hit) ? S_LOCKOUT : S_IDLE;
`else
                w_state_nxt = S_IDLE;
`endif
            end
`ifdef CODE_CHECK_LOCKOUT_EN
            S_LOCKOUT: if (w_lock_hit) w_state_nxt = S_IDLE;
`endif
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        w_buf_nxt    = r_buf;
        w_cnt_nxt    = r_cnt;
        w_tmo_nxt    = r_tmo;
        w_status_nxt = r_status;
        w_stb_nxt    = 1'b0;
`ifdef CODE_CHECK_LOCKOUT_EN
        w_fail_nxt   = r_fail;
        w_lock_nxt   = r_lock;
        w_locked_nxt = r_locked;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_kb_rise) begin
                    w_buf_nxt    = w_buf_shift;
                    w_cnt_nxt    = CNT_W'(1);
                    w_tmo_nxt    = '0;
                    w_status_nxt = ST_BUSY;
                end
            end
            S_ENTRY: begin
                if (w_kb_rise) begin
                    w_buf_nxt = w_buf_shift;
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    w_tmo_nxt = '0;
                end else if (w_tmo_hit) begin
                    w_cnt_nxt    = '0;
                    w_tmo_nxt    = '0;
                    w_status_nxt = ST_NONE;
                end else begin
                    w_tmo_nxt = r_tmo + TMO_W'(1);
                end
            end
            S_CHECK: begin
                w_cnt_nxt = '0;
                w_stb_nxt = 1'b1;
                if (w_match) begin
                    w_status_nxt = ST_OK;
`ifdef CODE_CHECK_LOCKOUT_EN
                    w_fail_nxt   = '0;
`endif
                end else begin
                    w_status_nxt = ST_ERR;
`ifdef CODE_CHECK_LOCKOUT_EN
                    if (w_fail_hit) begin
                        w_fail_nxt   = FAIL_W'(MAX_TRIES);
                        w_lock_nxt   = '0;
                        w_locked_nxt = 1'b1;
                    end else begin
                        w_fail_nxt = r_fail + FAIL_W'(1);
                    end
`endif
                end
            end
`ifdef CODE_CHECK_LOCKOUT_EN
            S_LOCKOUT: begin
                if (w_lock_hit) begin
                    w_lock_nxt   = '0;
                    w_locked_nxt = 1'b0;
                    w_fail_nxt   = '0;
                    w_status_nxt = ST_NONE;
                end else begin
                    w_lock_nxt = r_lock + LOCK_W'(1);
                end
            end
`endif
            default: ;
        endcase
    end

    assign KEY_STATUS = r_status;
    assign RESULT_STB = r_stb;
    assign DIGIT_CNT  = r_cnt;

endmodule

// File: tb/tb_code_check_seq.sv
// Directed bench for code_check_seq: a 2-bit/4-digit instance and a 4-bit/6-digit instance.
`timescale 1ns/1ps
module tb_code_check_seq;
    localparam logic [1:0] OK = 2'd0, BUSY = 2'd1, ERR = 2'd2, NONE = 2'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic        kb_recv0, kb_recv1;
    logic [1:0]  kb_in0;
    logic [3:0]  kb_in1;
    logic [7:0]  key0 = 8'hE4;
    logic [23:0] key1 = 24'h5A3C91;
    logic [1:0]  st0, st1;
    logic        stb0, stb1, lk0, lk1;
    logic [2:0]  cnt0, cnt1;

    int n_vec = 0;
    int n_err = 0;
    int stb_cnt0 = 0;
    int lk_cyc0 = 0;

    always #5 clk = ~clk;

    code_check_seq #(.DIGIT_W(2), .CODE_LEN(4), .TIMEOUT_CYCLES(10), .MAX_TRIES(3), .LOCK_CYCLES(20)) dut0 (
        .CLK(clk), .RST(rst), .KB_RECV(kb_recv0), .KB_IN(kb_in0), .VALID_KEY(key0),
        .KEY_STATUS(st0), .RESULT_STB(stb0), .LOCKED(lk0), .DIGIT_CNT(cnt0));

    code_check_seq #(.DIGIT_W(4), .CODE_LEN(6), .TIMEOUT_CYCLES(1000), .MAX_TRIES(8), .LOCK_CYCLES(20)) dut1 (
        .CLK(clk), .RST(rst), .KB_RECV(kb_recv1), .KB_IN(kb_in1), .VALID_KEY(key1),
        .KEY_STATUS(st1), .RESULT_STB(stb1), .LOCKED(lk1), .DIGIT_CNT(cnt1));

    always @(posedge clk) begin
        if (stb0) stb_cnt0 <= stb_cnt0 + 1;
        if (lk0)  lk_cyc0  <= lk_cyc0 + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int          inst;
        logic [23:0] code;
        logic [1:0]  exp_st;
        logic        exp_lk;
        string       name;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int st_of(input int inst);
        return (inst == 0) ? int'(st0) : int'(st1);
    endfunction
    function automatic int stb_of(input int inst);
        return (inst == 0) ? int'(stb0) : int'(stb1);
    endfunction
    function automatic int lk_of(input int inst);
        return (inst == 0) ? int'(lk0) : int'(lk1);
    endfunction
    function automatic int cnt_of(input int inst);
        return (inst == 0) ? int'(cnt0) : int'(cnt1);
    endfunction

    // Strobe one digit (2 cycles high, 2 low); snapshot outputs 2 and 3 edges after the first sampling edge
    task automatic send_digit(input int inst, input logic [3:0] d,
                              output int cnt_r, output int st_r, output int stb_r,
                              output int st_v, output int stb_v);
        if (inst == 0) begin kb_in0 = d[1:0]; kb_recv0 = 1'b1; end
        else           begin kb_in1 = d;      kb_recv1 = 1'b1; end
        tick();
        tick();
        kb_recv0 = 1'b0;
        kb_recv1 = 1'b0;
        tick();
        cnt_r = cnt_of(inst);
        st_r  = st_of(inst);
        stb_r = stb_of(inst);
        tick();
        st_v  = st_of(inst);
        stb_v = stb_of(inst);
    endtask

    task automatic apply_code(input int inst, input logic [23:0] code, input logic [1:0] exp_st,
                              input logic exp_lk, input string nm);
        int len, dw, c, s2, b2, s3, b3;
        logic [23:0] sh;
        logic [3:0]  d;
        len = (inst == 0) ? 4 : 6;
        dw  = (inst == 0) ? 2 : 4;
        sh  = code;
        c = 0; s2 = 0; b2 = 0; s3 = 0; b3 = 0;
        for (int i = 0; i < len; i++) begin
            d  = (dw == 2) ? {2'b00, sh[1:0]} : sh[3:0];
            sh = sh >> dw;
            send_digit(inst, d, c, s2, b2, s3, b3);
            chk({nm, " digit_cnt"}, c, i + 1);
        end
        chk({nm, " stb_early"}, b2, 0);
        chk({nm, " verdict"}, s3, int'(exp_st));
        chk({nm, " stb"}, b3, 1);
        tick();
        chk({nm, " stb_one_cycle"}, stb_of(inst), 0);
        chk({nm, " cnt_clear"}, cnt_of(inst), 0);
        chk({nm, " locked"}, lk_of(inst), int'(exp_lk));
    endtask

    initial begin
        vec_t tbl[$];
        int c, s2, b2, s3, b3, snap, lk_snap, budget;

        tbl.push_back('{0, 24'h0000E4, OK,  1'b0, "v0_ok"});
        tbl.push_back('{0, 24'h0000A4, ERR, 1'b0, "v0_0122"});
        tbl.push_back('{0, 24'h0000E4, OK,  1'b0, "v0_ok2"});
        tbl.push_back('{1, 24'h5A3C91, OK,  1'b0, "v1_ok"});
        for (int k = 0; k < 5; k++)
            tbl.push_back('{1, 24'h5A3C90, ERR, 1'b0, "v1_wrong"});
        tbl.push_back('{1, 24'h5A3C91, OK,  1'b0, "v1_ok2"});
        tbl.push_back('{0, 24'h00001B, ERR, 1'b0, "v0_3210"});

        rst = 1'b1; kb_recv0 = 1'b0; kb_recv1 = 1'b0; kb_in0 = '0; kb_in1 = '0;
        tick(); tick(); tick();
        chk("reset status", int'(st0), int'(NONE));
        chk("reset stb", int'(stb0), 0);
        chk("reset locked", int'(lk0), 0);
        chk("reset cnt", int'(cnt0), 0);
        chk("reset status1", int'(st1), int'(NONE));
        rst = 1'b0;
        tick();

        foreach (tbl[i]) apply_code(tbl[i].inst, tbl[i].code, tbl[i].exp_st, tbl[i].exp_lk, tbl[i].name);

        // New first digit after a verdict shows BUSY; then let the entry time out
        send_digit(0, 4'd0, c, s2, b2, s3, b3);
        chk("busy status", s2, int'(BUSY));
        chk("busy cnt", c, 1);
        send_digit(0, 4'd1, c, s2, b2, s3, b3);
        chk("second cnt", c, 2);
        snap = stb_cnt0;
        for (int k = 0; k < 5; k++) tick();
        chk("pre_timeout status", int'(st0), int'(BUSY));
        chk("pre_timeout cnt", int'(cnt0), 2);
        for (int k = 0; k < 6; k++) tick();
        chk("timeout status", int'(st0), int'(NONE));
        chk("timeout cnt", int'(cnt0), 0);
        chk("timeout no stb", stb_cnt0 - snap, 0);
        apply_code(0, 24'hE4, OK, 1'b0, "after_timeout");

`ifdef CODE_CHECK_LOCKOUT_EN
        lk_snap = lk_cyc0;
        apply_code(0, 24'hA4, ERR, 1'b0, "lk_try1");
        apply_code(0, 24'hA4, ERR, 1'b0, "lk_try2");
        apply_code(0, 24'hA4, ERR, 1'b1, "lk_try3");
        chk("lockout status", int'(st0), int'(ERR));
        send_digit(0, 4'd0, c, s2, b2, s3, b3);
        chk("lockout digit ignored", c, 0);
        chk("lockout status hold", s2, int'(ERR));
        budget = 100;
        while (lk0 && budget > 0) begin
            tick();
            budget--;
        end
        chk("lockout ends", int'(lk0), 0);
        chk("lockout length", lk_cyc0 - lk_snap, 20);
        chk("post_lock status", int'(st0), int'(NONE));
`else
        lk_snap = 0;
        budget  = 0;
        apply_code(0, 24'hA4, ERR, 1'b0, "nolk_try1");
        apply_code(0, 24'hA4, ERR, 1'b0, "nolk_try2");
        apply_code(0, 24'hA4, ERR, 1'b0, "nolk_try3");
        apply_code(0, 24'hA4, ERR, 1'b0, "nolk_try4");
`endif
        apply_code(0, 24'hE4, OK, 1'b0, "after_lock");

        // Reset in the middle of an entry
        send_digit(0, 4'd0, c, s2, b2, s3, b3);
        send_digit(0, 4'd1, c, s2, b2, s3, b3);
        chk("pre_reset cnt", c, 2);
        rst = 1'b1;
        tick();
        chk("mid_reset status", int'(st0), int'(NONE));
        chk("mid_reset stb", int'(stb0), 0);
        chk("mid_reset locked", int'(lk0), 0);
        chk("mid_reset cnt", int'(cnt0), 0);
        rst = 1'b0;
        tick();
        apply_code(0, 24'hE4, OK, 1'b0, "after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
